aes_byte_collector: RTL and testbench
=====================================

# aes_byte_collector

Receive-side deserializer for the AES core's byte-serial result port. It captures 16 consecutive bytes from `AES_TOP.finalout` and assembles them into one 128-bit ciphertext block. It then presents the block to downstream logic through a valid/ready handshake. A single output holding register lets the next block fill while the previous one waits to be accepted. Sticky flags report dropped blocks and framing errors.

## Interface
- `BLOCK_BYTES`, default 16: number of bytes per block. The output width is `8*BLOCK_BYTES`. Only 16 is verified.
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `byte_in`, input, 8: byte from the core's `finalout`. Sampled only when `byte_valid`=1.
- `byte_valid`, input, 1: `byte_in` carries a valid byte this cycle.
- `byte_sof`, input, 1: start of block. Qualified by `byte_valid`; marks byte 0 of a block.
- `block_out`, output, 128: assembled block. Byte 0 sits in bits [127:120] and byte 15 in bits [7:0].
- `block_valid`, output, 1: `block_out` holds an unaccepted block.
- `block_ready`, input, 1: downstream accepts the block when `block_valid`=1 and `block_ready`=1.
- `err_clr`, input, 1: synchronous clear of both sticky flags.
- `overflow`, output, 1: sticky. A completed block was dropped because the holding register was occupied.
- `frame_err`, output, 1: sticky. `byte_sof` arrived while a partial block was in progress.
- `fill_count`, output, 4: number of bytes currently held in the assembly register.

## Operation
- **Reset values:** all outputs are 0. This covers `block_out`, `block_valid`, `overflow`, `frame_err` and `fill_count`. The assembly register is also cleared.
- **Assembly state.** Bytes accumulate in a 128-bit assembly register plus the counter `cnt` (0..15, driven out as `fill_count`).
  - FILL is `cnt`≥1. EMPTY is `cnt`=0.
  - Output side: HOLD is `block_valid`=1. FREE is `block_valid`=0.
- **Accepting a byte.** On each edge with `byte_valid`=1:
  - If `byte_sof`=1: the byte is written to bits [127:120] and `cnt` becomes 1. If `cnt`≠0 beforehand, the partial block is discarded and `frame_err` is set.
  - If `byte_sof`=0: byte k=`cnt` is written to bits [127-8k -: 8] and `cnt` increments.
  - A byte arriving in EMPTY without `byte_sof` is accepted as byte 0. The core carries no framing, so framing is optional.
- **Completion.** The byte accepted with `cnt`=15 completes the block, and `cnt` wraps to 0.
  - If the output is FREE, or an accept (`block_valid`&`block_ready`) happens on the same edge, the full block is loaded into `block_out` on that edge and `block_valid`=1.
  - Otherwise the block is dropped, `block_out` is unchanged and `overflow` is set.
- **Output handshake.**
  - `block_out` stays stable while `block_valid`=1.
  - An accept clears `block_valid` on the same edge, unless a completion reloads it on that edge (see completion above).
  - `block_ready` while `block_valid`=0 has no effect.
- **Sticky flags.**
  - `err_clr` clears `overflow` and `frame_err` on the next edge.
  - If `err_clr` and a setting event occur on the same edge, the flag ends up set.
- `err_clr` does not affect the data path.
- **Reset mid-block:** the partial block and any held block are lost.

## Timing
- **Latency.** The last byte is sampled on edge N. `block_out` and `block_valid` are valid from edge N onward, so downstream sees them in cycle N+1.
- **Throughput.** One byte per clock is accepted continuously. There is no input backpressure (the core has none). Back-to-back blocks therefore complete every 16 cycles.
- **Drain requirement.** Downstream must accept within 16 cycles of `block_valid` rising to avoid `overflow` at full input rate.
- `fill_count` updates on the same edge as the byte capture.
- The `overflow` and `frame_err` set conditions are registered: the flag is visible in the cycle after the offending edge.
- **No combinational paths** from any input to any output.

## Test plan
- **Reset:** assert `rst_n`=0 mid-block at `fill_count`=7 → all outputs read 0 immediately, including `fill_count`=0. After release, a fresh 16-byte block assembles correctly.
- **Single block:** drive FIPS-197 ciphertext bytes 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32, with sof on the first byte and `block_ready`=0 → after the 16th edge, `block_out`=128'h3925841d02dc09fbdc118597196a0b32 and `block_valid`=1, held stable. Then `block_ready`=1 for one cycle → `block_valid`=0.
- **Back-to-back blocks:** 32 consecutive bytes 00..1f with `block_ready`=1 throughout → two blocks, 128'h000102…0f then 128'h101112…1f, with `block_valid` pulsing for one cycle each. No flags are set.
- **Simultaneous accept and completion:** hold block A, then complete block B on the same edge `block_ready`=1 → `block_valid` stays 1, `block_out`=B and `overflow`=0.
- **Overflow:** `block_ready`=0 across two complete blocks → `block_out` keeps the first block and `overflow`=1. Then `err_clr` → `overflow`=0 on the next cycle.
- **Framing error:** 5 bytes, then sof with byte aa followed by 15 bytes bb → `frame_err`=1 and `block_out`=128'haabbbb…bb. The 5 discarded bytes do not appear.

Source files
------------

// File: rtl/aes_byte_collector.sv
// Deserializer for the AES core's byte-serial result port: packs BLOCK_BYTES bytes
// into one block and offers it downstream through a single valid/ready holding register.
module aes_byte_collector #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  input  logic                     byte_sof,
  output logic [8*BLOCK_BYTES-1:0] block_out,
  output logic                     block_valid,
  input  logic                     block_ready,
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     frame_err,
  output logic [3:0]               fill_count
);

  localparam int         W    = 8 * BLOCK_BYTES;
  localparam logic [3:0] LAST = 4'(BLOCK_BYTES - 1);

  logic [W-1:0] asm_q;
  logic [W-1:0] asm_nxt;
  logic [3:0]   cnt;
  logic         accept;
  logic         complete;
  logic         sof_err;
  logic         drop;

  assign accept   = block_valid & block_ready;
  assign complete = byte_valid & ~byte_sof & (cnt == LAST);
  assign sof_err  = byte_valid & byte_sof & (cnt != 4'd0);
  assign drop     = complete & block_valid & ~block_ready;
  assign fill_count = cnt;

  // Assembly register with the incoming byte already merged, so a completing
  // byte can be loaded into the holding register on the same edge.
  always_comb begin
    asm_nxt = asm_q;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (byte_valid && ((byte_sof && i == 0) || (!byte_sof && i == int'(cnt)))) begin
        asm_nxt[W-8-8*i +: 8] = byte_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q       <= '0;
      cnt         <= '0;
      block_out   <= '0;
      block_valid <= 1'b0;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      asm_q <= asm_nxt;
      if (byte_valid) begin
        if (byte_sof) begin
          cnt <= 4'd1;
        end else if (complete) begin
          cnt <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
      if (complete && !drop) begin
        block_out   <= asm_nxt;
        block_valid <= 1'b1;
      end else if (accept) begin
        block_valid <= 1'b0;
      end
      // Set wins over clear when both land on the same edge.
      overflow  <= (overflow  & ~err_clr) | drop;
      frame_err <= (frame_err & ~err_clr) | sof_err;
    end
  end

endmodule

// File: tb/tb_aes_byte_collector.sv
// Self-checking bench for aes_byte_collector: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based behavioural model.
module tb_aes_byte_collector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_sof;
  logic [127:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic         err_clr;
  logic         overflow;
  logic         frame_err;
  logic [3:0]   fill_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]   mq[$];
  logic [127:0] m_data;
  logic         m_valid;
  logic         m_ovf;
  logic         m_ferr;

  aes_byte_collector #(.BLOCK_BYTES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_sof   (byte_sof),
    .block_out  (block_out),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .err_clr    (err_clr),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_ferr  = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic s, input logic [7:0] b,
                                     input logic r, input logic c);
    logic         acc;
    logic         done;
    logic         set_o;
    logic         set_f;
    logic [127:0] blk;
    acc   = m_valid & r;
    done  = 1'b0;
    set_o = 1'b0;
    set_f = 1'b0;
    blk   = '0;
    if (v) begin
      if (s) begin
        if (mq.size() != 0) set_f = 1'b1;
        mq.delete();
      end
      mq.push_back(b);
      if (mq.size() == 16) begin
        done = 1'b1;
        foreach (mq[i]) blk[127-8*i -: 8] = mq[i];
        mq.delete();
      end
    end
    if (done) begin
      if (!m_valid || acc) begin
        m_data  = blk;
        m_valid = 1'b1;
      end else begin
        set_o = 1'b1;
      end
    end else if (acc) begin
      m_valid = 1'b0;
    end
    if (c) begin
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
    end
    if (set_o) m_ovf = 1'b1;
    if (set_f) m_ferr = 1'b1;
  endfunction

  task automatic check_outputs();
    chk("block_valid", 128'(block_valid), 128'(m_valid));
    chk("block_out",   block_out,         m_data);
    chk("fill_count",  128'(fill_count),  128'(mq.size()));
    chk("overflow",    128'(overflow),    128'(m_ovf));
    chk("frame_err",   128'(frame_err),   128'(m_ferr));
  endtask

  task automatic cyc(input logic v, input logic s, input logic [7:0] b,
                     input logic r, input logic c);
    byte_valid  = v;
    byte_sof    = s;
    byte_in     = b;
    block_ready = r;
    err_clr     = c;
    @(posedge clk);
    model_step(v, s, b, r, c);
    #1;
    check_outputs();
  endtask

  task automatic feed_block(input logic [127:0] blk, input logic r_last);
    logic [127:0] tmp;
    tmp = blk;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, i == 0, tmp[127-8*i -: 8], (i == 15) ? r_last : 1'b0, 1'b0);
    end
  endtask

  logic [127:0] blk_a;
  logic [127:0] blk_b;
  logic [7:0]   fips[16];

  initial begin
    fips = '{8'h39, 8'h25, 8'h84, 8'h1d, 8'h02, 8'hdc, 8'h09, 8'hfb,
             8'hdc, 8'h11, 8'h85, 8'h97, 8'h19, 8'h6a, 8'h0b, 8'h32};
    rst_n       = 1'b0;
    byte_in     = 8'h00;
    byte_valid  = 1'b0;
    byte_sof    = 1'b0;
    block_ready = 1'b0;
    err_clr     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a block at fill_count 7
    for (int i = 0; i < 7; i++) cyc(1'b1, i == 0, 8'($urandom), 1'b0, 1'b0);
    chk("fill_before_reset", 128'(fill_count), 128'(7));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_fill_count",  128'(fill_count),  128'(0));
    chk("rst_block_valid", 128'(block_valid), 128'(0));
    chk("rst_block_out",   block_out,         128'(0));
    chk("rst_flags",       128'({overflow, frame_err}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 ciphertext, held with ready low
    for (int i = 0; i < 16; i++) cyc(1'b1, i == 0, fips[i], 1'b0, 1'b0);
    chk("fips_block", block_out, 128'h3925841d02dc09fbdc118597196a0b32);
    chk("fips_valid", 128'(block_valid), 128'(1));
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("fips_stable", block_out, 128'h3925841d02dc09fbdc118597196a0b32);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("fips_accepted", 128'(block_valid), 128'(0));

    // Back-to-back blocks with ready high throughout
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, (i % 16) == 0, 8'(i), 1'b1, 1'b0);
      if (i == 15) chk("b2b_first", block_out, 128'h000102030405060708090a0b0c0d0e0f);
      if (i == 16) chk("b2b_pulse", 128'(block_valid), 128'(0));
      if (i == 31) chk("b2b_second", block_out, 128'h101112131415161718191a1b1c1d1e1f);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("b2b_flags", 128'({overflow, frame_err}), 128'(0));

    // Accept of A coincides with completion of B
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    feed_block(blk_a, 1'b0);
    feed_block(blk_b, 1'b1);
    chk("simul_valid", 128'(block_valid), 128'(1));
    chk("simul_out",   block_out, blk_b);
    chk("simul_ovf",   128'(overflow), 128'(0));
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow: two blocks with no accept
    feed_block(blk_a, 1'b0);
    feed_block(blk_b, 1'b0);
    chk("ovf_keeps_first", block_out, blk_a);
    chk("ovf_set", 128'(overflow), 128'(1));
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 128'(overflow), 128'(0));
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Framing error: partial block discarded by an early sof
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'haa, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 8'hbb, 1'b0, 1'b0);
    chk("ferr_set", 128'(frame_err), 128'(1));
    chk("ferr_block", block_out, {8'haa, {15{8'hbb}}});
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, 8'($urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
